// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter granting two requesters one outstanding transaction on a memory daisy-chain bus
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_addr_i/data_i/rw_i  requester N transaction (rw 1 = write)
//   reqN_valid_i             requester N holds a transaction
//   reqN_ready_o             requester N accepted this cycle
//   reqN_data_o/done_o       response data and one-cycle completion pulse
//   addr_o/data_o/rw_o/valid_o  head of the daisy-chain bus
//   addr_i/data_i/rw_i/valid_i  tail of the daisy-chain bus
//   timeout_o                one-cycle pulse when a transaction is abandoned
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req0_addr_i,
    input  logic [15:0] req0_data_i,
    input  logic        req0_rw_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    output logic [15:0] req0_data_o,
    output logic        req0_done_o,
    input  logic [15:0] req1_addr_i,
    input  logic [15:0] req1_data_i,
    input  logic        req1_rw_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    output logic [15:0] req1_data_o,
    output logic        req1_done_o,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic        timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] addr_q, addr_d, data_q, data_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic rw_q, rw_d, id_q, id_d, last_q, last_d, to_q, to_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic gnt0, gnt1, match;
    logic [15:0] resp;
    // last_q holds the requester served most recently; a tie goes to the other one
    assign gnt0 = !rst && state_q == IDLE && req0_valid_i && (!req1_valid_i || last_q);
    assign gnt1 = !rst && state_q == IDLE && req1_valid_i && (!req0_valid_i || !last_q);
    assign match = valid_i && addr_i == addr_q && rw_i == rw_q;
    assign resp = match ? data_i : 16'h0000;
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        data_d = data_q;
        rw_d = rw_q;
        id_d = id_q;
        last_d = last_q;
        to_d = to_q;
        cnt_d = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: if (gnt0 || gnt1) begin
                id_d = gnt1;
                addr_d = gnt1 ? req1_addr_i : req0_addr_i;
                data_d = gnt1 ? req1_data_i : req0_data_i;
                rw_d = gnt1 ? req1_rw_i : req0_rw_i;
                to_d = 1'b0;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // a match wins over a timeout landing in the same cycle
                if (match || cnt_d == CW'(TIMEOUT)) begin
                    rdata0_d = id_q ? rdata0_q : resp;
                    rdata1_d = id_q ? resp : rdata1_q;
                    to_d = !match;
                    state_d = DONE;
                end
            end
            default: begin
                last_d = id_q;
                to_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            rw_q <= 1'b0;
            id_q <= 1'b0;
            last_q <= 1'b1;
            to_q <= 1'b0;
            cnt_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            rw_q <= rw_d;
            id_q <= id_d;
            last_q <= last_d;
            to_q <= to_d;
            cnt_q <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign req0_data_o = rdata0_q;
    assign req1_data_o = rdata1_q;
    assign req0_done_o = state_q == DONE && !id_q;
    assign req1_done_o = state_q == DONE && id_q;
    assign timeout_o = state_q == DONE && to_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign rw_o = rw_q;
    assign valid_o = state_q == ISSUE;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter on a 3-stage 8-deep memory chain
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] req0_addr_i = '0, req0_data_i = '0, req1_addr_i = '0, req1_data_i = '0;
    logic req0_rw_i = 1'b0, req0_valid_i = 1'b0, req1_rw_i = 1'b0, req1_valid_i = 1'b0;
    logic req0_ready_o, req1_ready_o, req0_done_o, req1_done_o, rw_o, valid_o, timeout_o;
    logic [15:0] req0_data_o, req1_data_o, addr_o, data_o;
    logic [15:0] addr_i, data_i;
    logic rw_i, valid_i;
    logic disc = 1'b0, inj = 1'b0;
    logic [15:0] inj_addr = '0;
    logic [15:0] mem [0:2][0:7];
    logic [15:0] sa [0:2], sd [0:2];
    logic sr [0:2], sv [0:2];
    int checks = 0, failures = 0, n_done = 0, cyc = 0, t_issue = 0;
    typedef struct { logic [15:0] addr; logic [15:0] wdata; logic rw; } bus_t;
    typedef struct { logic id; logic [15:0] data; logic to; } done_t;
    bus_t bus_q[$];
    done_t done_q[$];

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i), .req0_rw_i(req0_rw_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_data_o(req0_data_o),
        .req0_done_o(req0_done_o),
        .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i), .req1_rw_i(req1_rw_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_data_o(req1_data_o),
        .req1_done_o(req1_done_o),
        .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(addr_i), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory chain: stage s owns addresses 8*s..8*s+7, one register per stage
    initial begin
        for (int s = 0; s < 3; s++) begin
            sv[s] = 1'b0; sa[s] = '0; sd[s] = '0; sr[s] = 1'b0;
            for (int k = 0; k < 8; k++) mem[s][k] = 16'(8 * s + k);
        end
    end
    always @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            logic [15:0] ia, id, od;
            logic ir, iv;
            int p;
            p = (s == 0) ? 0 : s - 1;
            ia = (s == 0) ? addr_o : sa[p];
            id = (s == 0) ? data_o : sd[p];
            ir = (s == 0) ? rw_o : sr[p];
            iv = (s == 0) ? valid_o : sv[p];
            od = id;
            if (iv && ia[15:3] == 13'(s)) begin
                if (ir) mem[s][ia[2:0]] <= id;
                else od = mem[s][ia[2:0]];
            end
            sa[s] <= ia; sd[s] <= od; sr[s] <= ir; sv[s] <= iv;
        end
    end
    assign addr_i = inj ? inj_addr : sa[2];
    assign data_i = inj ? 16'h5555 : sd[2];
    assign rw_i = inj ? 1'b0 : sr[2];
    assign valid_i = !disc && (inj || sv[2]);

    wire any_out = |{req0_ready_o, req1_ready_o, req0_data_o, req1_data_o, req0_done_o,
                     req1_done_o, addr_o, data_o, rw_o, valid_o, timeout_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_txn(input logic id, input logic [15:0] a, input logic [15:0] wd,
                           input logic r, input logic [15:0] rd, input logic to);
        bus_q.push_back('{addr: a, wdata: wd, rw: r});
        done_q.push_back('{id: id, data: rd, to: to});
    endtask

    // monitor: bus issues and completions are popped against the scoreboard
    always @(negedge clk) begin
        if (valid_o) begin
            if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
            else begin
                bus_t b;
                b = bus_q.pop_front();
                chk("bus_addr", 32'(addr_o), 32'(b.addr));
                chk("bus_rw", 32'(rw_o), 32'(b.rw));
                chk("bus_data", 32'(data_o), 32'(b.wdata));
            end
            t_issue = cyc;
        end
        if (req0_done_o || req1_done_o) begin
            chk("done_single", 32'(req0_done_o && req1_done_o), 0);
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                done_t e;
                e = done_q.pop_front();
                chk("done_id", 32'(req1_done_o), 32'(e.id));
                chk("done_data", 32'(e.id ? req1_data_o : req0_data_o), 32'(e.data));
                chk("done_timeout", 32'(timeout_o), 32'(e.to));
                chk("done_latency", 32'(cyc - t_issue), e.to ? 32'd5 : 32'd4);
            end
            n_done++;
        end else if (timeout_o) chk("timeout_alone", 1, 0);
    end

    task automatic do_req(input logic id, input logic [15:0] a, input logic [15:0] d, input logic r);
        bit got = 0;
        @(negedge clk);
        if (id) begin req1_addr_i = a; req1_data_i = d; req1_rw_i = r; req1_valid_i = 1'b1; end
        else begin req0_addr_i = a; req0_data_i = d; req0_rw_i = r; req0_valid_i = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            #1;
            if (id ? req1_ready_o : req0_ready_o) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) chk("grant_wait", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
        if (id) req1_valid_i = 1'b0;
        else req0_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 200 && n_done < n; i++) @(negedge clk);
        if (n_done < n) chk("done_wait", 32'(n_done), 32'(n));
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid_o) begin seen = 1; break; end
        end
        if (!seen) chk("valid_wait", 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(any_out), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 32'(any_out), 0);
        // single read
        exp_txn(0, 16'h0001, 16'h0000, 0, 16'h0001, 0);
        do_req(0, 16'h0001, 16'h0000, 0);
        wait_done(1);
        // write then read on req1, plus an untouched neighbour
        exp_txn(1, 16'h0012, 16'h0069, 1, 16'h0069, 0);
        do_req(1, 16'h0012, 16'h0069, 1);
        wait_done(2);
        exp_txn(1, 16'h0012, 16'h0000, 0, 16'h0069, 0);
        do_req(1, 16'h0012, 16'h0000, 0);
        wait_done(3);
        exp_txn(1, 16'h0011, 16'h0000, 0, 16'h0011, 0);
        do_req(1, 16'h0011, 16'h0000, 0);
        wait_done(4);
        @(negedge clk);
        chk("req0_data_hold", 32'(req0_data_o), 32'h0001);
        chk("req1_data_hold", 32'(req1_data_o), 32'h0011);
        // ties from reset: req0, req1, then req0 again
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_txn(0, 16'h000A, 16'h0000, 0, 16'h000A, 0);
        exp_txn(1, 16'h0003, 16'h0000, 0, 16'h0003, 0);
        fork
            do_req(0, 16'h000A, 16'h0000, 0);
            do_req(1, 16'h0003, 16'h0000, 0);
        join
        wait_done(6);
        exp_txn(0, 16'h000B, 16'h0000, 0, 16'h000B, 0);
        exp_txn(1, 16'h0013, 16'h0000, 0, 16'h0013, 0);
        fork
            do_req(0, 16'h000B, 16'h0000, 0);
            do_req(1, 16'h0013, 16'h0000, 0);
        join
        wait_done(8);
        // spurious return with the wrong address while waiting
        exp_txn(0, 16'h0001, 16'h0000, 0, 16'h0001, 0);
        fork
            do_req(0, 16'h0001, 16'h0000, 0);
            begin
                wait_valid();
                inj_addr = 16'h0005;
                inj = 1'b1;
                repeat (2) @(negedge clk);
                inj = 1'b0;
            end
        join
        wait_done(9);
        // timeout with the tail disconnected
        disc = 1'b1;
        exp_txn(0, 16'h0003, 16'h0000, 0, 16'h0000, 1);
        do_req(0, 16'h0003, 16'h0000, 0);
        wait_done(10);
        disc = 1'b0;
        // reset mid-WAIT: no completion, late return ignored
        bus_q.push_back('{addr: 16'h0004, wdata: 16'h0000, rw: 1'b0});
        do_req(1, 16'h0004, 16'h0000, 0);
        wait_valid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_mid_outputs", 32'(any_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_done_after_reset", 32'(n_done), 10);
        exp_txn(0, 16'h0007, 16'h0000, 0, 16'h0007, 0);
        do_req(0, 16'h0007, 16'h0000, 0);
        wait_done(11);
        @(negedge clk);
        chk("scoreboard_empty", 32'(bus_q.size() + done_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
